// File: rtl/token_engine_pkg.sv
// Shared types and constants for the PE-array token sequencer.
package token_engine_pkg;

  localparam int PE_ARRAY_DIM = 32;
  localparam int DRAIN_CYCLES = 32;

  localparam logic [1:0] LT_PW  = 2'b00;
  localparam logic [1:0] LT_DW  = 2'b01;
  localparam logic [1:0] LT_STD = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PREHEAT,
    ST_NORMAL,
    ST_DRAIN,
    ST_DONE
  } seq_state_e;

  // Bits [lim:0] set, the rest clear.
  function automatic logic [PE_ARRAY_DIM-1:0] prefix_mask(input logic [4:0] lim);
    logic [PE_ARRAY_DIM-1:0] m;
    for (int i = 0; i < PE_ARRAY_DIM; i++) m[i] = (i <= int'(lim));
    return m;
  endfunction

endpackage

// File: rtl/fifo_ready_reduce.sv
// Masked AND-reduction of per-column ready; columns above limit are don't-care.
module fifo_ready_reduce
  import token_engine_pkg::*;
(
  input  logic [PE_ARRAY_DIM-1:0] mask,
  input  logic [PE_ARRAY_DIM-1:0] ready,
  input  logic [4:0]              limit,
  output logic                    all_ready
);

  logic [PE_ARRAY_DIM-1:0] col_ok;

  for (genvar j = 0; j < PE_ARRAY_DIM; j++) begin : g_col
    assign col_ok[j] = ready[j] | ~mask[j] | (int'(limit) < j);
  end

  assign all_ready = &col_ok;

endmodule

// File: rtl/pe_array_token_sequencer.sv
// Sequences a PE-array job through preheat, normal token loop and drain.
// Optional stall counter output enabled by defining SEQ_PERF_CNT_EN.
module pe_array_token_sequencer
  import token_engine_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start_i,
  input  logic [1:0]  layer_type_i,
  input  logic [31:0] col_en_mask_i,
  input  logic [15:0] num_tokens_i,
  input  logic [31:0] ifmap_fifo_empty_i,
  input  logic [31:0] ipsum_fifo_empty_i,
  input  logic [31:0] opsum_fifo_full_i,
  output logic        preheat_state_o,
  output logic        normal_loop_state_o,
  output logic [31:0] ifmap_fifo_pop_matrix_o,
  output logic [31:0] ipsum_fifo_pop_matrix_o,
  output logic [31:0] opsum_fifo_push_matrix_o,
  output logic        pe_array_move_o,
  output logic        busy_o,
  output logic        done_o
`ifdef SEQ_PERF_CNT_EN
  ,
  output logic [31:0] stall_cnt_o
`endif
);

  seq_state_e  state, state_nxt;
  logic [1:0]  layer_q;
  logic [31:0] mask_q;
  logic [15:0] ntok_q;
  logic [4:0]  k_q;
  logic [15:0] tok_cnt_q;
  logic [4:0]  drain_cnt_q;

  logic        bypass;
  logic [4:0]  if_limit;
  logic        if_rdy, ip_rdy, op_rdy;
  logic        step, nmove, dmove;
  logic        accept;

  assign bypass   = (layer_q == LT_DW);
  // Preheat only waits on the growing prefix of columns; elsewhere all columns count.
  assign if_limit = (state == ST_PREHEAT) ? k_q : 5'd31;

  fifo_ready_reduce u_if_rdy (
    .mask(mask_q), .ready(~ifmap_fifo_empty_i), .limit(if_limit), .all_ready(if_rdy)
  );
  fifo_ready_reduce u_ip_rdy (
    .mask(mask_q), .ready(~ipsum_fifo_empty_i | {32{bypass}}), .limit(5'd31), .all_ready(ip_rdy)
  );
  fifo_ready_reduce u_op_rdy (
    .mask(mask_q), .ready(~opsum_fifo_full_i), .limit(5'd31), .all_ready(op_rdy)
  );

  assign accept = (state == ST_IDLE) && start_i;
  assign step   = (state == ST_PREHEAT) && if_rdy;
  assign nmove  = (state == ST_NORMAL) && if_rdy && ip_rdy && op_rdy;
  assign dmove  = (state == ST_DRAIN) && op_rdy;
  assign busy_o = (state != ST_IDLE);

  always_comb begin
    state_nxt                = state;
    preheat_state_o          = 1'b0;
    normal_loop_state_o      = 1'b0;
    ifmap_fifo_pop_matrix_o  = '0;
    ipsum_fifo_pop_matrix_o  = '0;
    opsum_fifo_push_matrix_o = '0;
    pe_array_move_o          = 1'b0;
    done_o                   = 1'b0;
    unique case (state)
      ST_IDLE: if (start_i) state_nxt = ST_PREHEAT;
      ST_PREHEAT: begin
        preheat_state_o = 1'b1;
        if (step) begin
          ifmap_fifo_pop_matrix_o = mask_q & prefix_mask(k_q);
          if (k_q == 5'd31) state_nxt = (ntok_q != '0) ? ST_NORMAL : ST_DRAIN;
        end
      end
      ST_NORMAL: begin
        normal_loop_state_o = 1'b1;
        if (nmove) begin
          pe_array_move_o          = 1'b1;
          ifmap_fifo_pop_matrix_o  = mask_q;
          ipsum_fifo_pop_matrix_o  = bypass ? '0 : mask_q;
          opsum_fifo_push_matrix_o = mask_q;
          if (tok_cnt_q + 16'd1 == ntok_q) state_nxt = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (dmove) begin
          pe_array_move_o          = 1'b1;
          opsum_fifo_push_matrix_o = mask_q;
          if (drain_cnt_q == 5'(DRAIN_CYCLES - 1)) state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        done_o    = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      layer_q     <= '0;
      mask_q      <= '0;
      ntok_q      <= '0;
      k_q         <= '0;
      tok_cnt_q   <= '0;
      drain_cnt_q <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        layer_q     <= layer_type_i;
        mask_q      <= col_en_mask_i;
        ntok_q      <= num_tokens_i;
        k_q         <= '0;
        tok_cnt_q   <= '0;
        drain_cnt_q <= '0;
      end else begin
        if (step)  k_q         <= k_q + 5'd1;
        if (nmove) tok_cnt_q   <= tok_cnt_q + 16'd1;
        if (dmove) drain_cnt_q <= drain_cnt_q + 5'd1;
      end
    end
  end

`ifdef SEQ_PERF_CNT_EN
  logic [31:0] stall_q;

  always_ff @(posedge clk) begin
    if (!rst_n)                                            stall_q <= '0;
    else if (accept)                                       stall_q <= '0;
    else if (busy_o && !(step || nmove || dmove) && (stall_q != '1)) stall_q <= stall_q + 32'd1;
  end

  assign stall_cnt_o = stall_q;
`endif

endmodule

// File: tb/tb_pe_array_token_sequencer.sv
// Directed bench for pe_array_token_sequencer with a per-cycle reference model.
module tb_pe_array_token_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start_i = 1'b0;
  logic [1:0]  layer_type = 2'b00;
  logic [31:0] col_en_mask = '0;
  logic [15:0] num_tokens = '0;
  logic [31:0] ifmap_empty = '0, ipsum_empty = '0, opsum_full = '0;
  logic        preheat_state, normal_loop_state, pe_array_move, busy, done;
  logic [31:0] ifmap_pop, ipsum_pop, opsum_push;
`ifdef SEQ_PERF_CNT_EN
  logic [31:0] stall_cnt;
`endif

  pe_array_token_sequencer dut (
    .clk(clk), .rst_n(rst_n), .start_i(start_i),
    .layer_type_i(layer_type), .col_en_mask_i(col_en_mask), .num_tokens_i(num_tokens),
    .ifmap_fifo_empty_i(ifmap_empty), .ipsum_fifo_empty_i(ipsum_empty),
    .opsum_fifo_full_i(opsum_full),
    .preheat_state_o(preheat_state), .normal_loop_state_o(normal_loop_state),
    .ifmap_fifo_pop_matrix_o(ifmap_pop), .ipsum_fifo_pop_matrix_o(ipsum_pop),
    .opsum_fifo_push_matrix_o(opsum_push), .pe_array_move_o(pe_array_move),
    .busy_o(busy), .done_o(done)
`ifdef SEQ_PERF_CNT_EN
    , .stall_cnt_o(stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  int vectors = 0, miscompares = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      if (miscompares <= 40)
        $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: phase 0 idle, 1 preheat, 2 normal, 3 drain, 4 done.
  int          m_ph = 0, m_k = 0, m_tok = 0, m_drain = 0;
  logic [31:0] m_mask = '0;
  logic [15:0] m_ntok = '0;
  bit          m_dw = 0;
  bit          fire, rdy;
  logic        e_move;
  logic [31:0] e_ifp, e_ipp, e_opp;

  always @(negedge clk) begin
    fire = 0; e_move = 0; e_ifp = '0; e_ipp = '0; e_opp = '0;
    case (m_ph)
      1: begin
        rdy = 1;
        for (int j = 0; j <= m_k; j++) if (m_mask[j] && ifmap_empty[j]) rdy = 0;
        if (rdy) begin
          e_ifp = m_mask & 32'((64'd1 << (m_k + 1)) - 64'd1);
          fire  = 1;
        end
      end
      2: begin
        rdy = 1;
        for (int j = 0; j < 32; j++)
          if (m_mask[j] && (ifmap_empty[j] || (!m_dw && ipsum_empty[j]) || opsum_full[j])) rdy = 0;
        if (rdy) begin
          e_move = 1; e_ifp = m_mask; e_ipp = m_dw ? '0 : m_mask; e_opp = m_mask; fire = 1;
        end
      end
      3: if ((m_mask & opsum_full) == '0) begin
        e_move = 1; e_opp = m_mask; fire = 1;
      end
      default: ;
    endcase
    chk("preheat_state", preheat_state, m_ph == 1);
    chk("normal_state", normal_loop_state, m_ph == 2);
    chk("busy", busy, m_ph != 0);
    chk("done", done, m_ph == 4);
    chk("move", pe_array_move, e_move);
    chk("ifmap_pop", ifmap_pop, e_ifp);
    chk("ipsum_pop", ipsum_pop, e_ipp);
    chk("opsum_push", opsum_push, e_opp);
    if (!rst_n) begin
      m_ph = 0; m_k = 0; m_tok = 0; m_drain = 0; m_mask = '0; m_ntok = '0; m_dw = 0;
    end else begin
      case (m_ph)
        0: if (start_i) begin
          m_ph = 1; m_k = 0; m_tok = 0; m_drain = 0;
          m_mask = col_en_mask; m_ntok = num_tokens; m_dw = (layer_type == 2'b01);
        end
        1: if (fire) begin
          if (m_k == 31) m_ph = (m_ntok != 0) ? 2 : 3;
          m_k++;
        end
        2: if (fire) begin
          m_tok++;
          if (m_tok == int'(m_ntok)) m_ph = 3;
        end
        3: if (fire) begin
          m_drain++;
          if (m_drain == 32) m_ph = 4;
        end
        default: m_ph = 0;
      endcase
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  // Leaves the bench #1 after the start edge, i.e. in the first PREHEAT cycle (cycle 1).
  task automatic start_job(input logic [31:0] mask, input logic [15:0] ntok, input logic [1:0] lt);
    col_en_mask = mask; num_tokens = ntok; layer_type = lt;
    start_i = 1'b1;
    step();
    start_i = 1'b0;
  endtask

  task automatic run_job(input int n0, output int done_at, output int nmv, output int dpush,
                         output int ipp);
    done_at = -1; nmv = 0; dpush = 0; ipp = 0;
    for (int n = n0; n < n0 + 200; n++) begin
      @(negedge clk);
      if (normal_loop_state && pe_array_move) nmv++;
      if (busy && !preheat_state && !normal_loop_state && pe_array_move) dpush++;
      if (ipsum_pop != '0) ipp++;
      if (done) begin
        done_at = n;
        break;
      end
    end
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  int  done_at, nmv, dpush, ipp;
  bit  seen;

  initial begin
    step(); step();
    @(negedge clk);
    chk("reset_busy", busy, 1'b0);
    chk("reset_strobes", {ifmap_pop, ipsum_pop, opsum_push}, '0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    step();

    // Full-mask job, 4 tokens, everything ready.
    start_job(32'hFFFF_FFFF, 16'd4, 2'b00);
    @(negedge clk); chk("lit_pop_k0", ifmap_pop, 32'h1);
    @(negedge clk); chk("lit_pop_k1", ifmap_pop, 32'h3);
    @(posedge clk); #1;
    run_job(3, done_at, nmv, dpush, ipp);
    chk("lit_done_cycle", done_at, 69);  // 70th cycle counting the start cycle as 1
    chk("lit_normal_moves", nmv, 4);
    chk("lit_drain_pushes", dpush, 32);

    // ifmap column 3 empty for 5 cycles while k=3.
    start_job(32'hFFFF_FFFF, 16'd1, 2'b00);
    step(); step(); step();
    ifmap_empty = 32'h0000_0008;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("lit_stall_pop", ifmap_pop, 32'h0);
      chk("lit_stall_pre", preheat_state, 1'b1);
      step();
    end
    ifmap_empty = '0;
    @(negedge clk); chk("lit_resume_pop", ifmap_pop, 32'hF);
    @(posedge clk); #1;
    run_job(10, done_at, nmv, dpush, ipp);
    chk("lit_stall_done", done_at, 71);

    // Depthwise: ipsum bypassed even though every ipsum FIFO is empty.
    ipsum_empty = '1;
    start_job(32'hFFFF_FFFF, 16'd3, 2'b01);
    run_job(1, done_at, nmv, dpush, ipp);
    chk("lit_dw_moves", nmv, 3);
    chk("lit_dw_ipsum_pops", ipp, 0);
    chk("lit_dw_done", done_at, 68);
    ipsum_empty = '0;

    // opsum[7] full blocks NORMAL; full bit 20 is outside the mask.
    opsum_full = 32'h0010_0080;
    start_job(32'h0000_00FF, 16'd2, 2'b10);
    seen = 0;
    for (int i = 0; i < 60 && !seen; i++) begin
      @(negedge clk);
      if (normal_loop_state) seen = 1;
    end
    chk("lit_reach_normal", seen, 1'b1);
    for (int i = 0; i < 4; i++) begin
      if (i > 0) @(negedge clk);
      chk("lit_full_move", pe_array_move, 1'b0);
      chk("lit_full_strobes", {ifmap_pop, ipsum_pop, opsum_push}, '0);
    end
    @(posedge clk); #1;
    opsum_full = 32'h0010_0000;
    @(negedge clk);
    chk("lit_unblock_move", pe_array_move, 1'b1);
    chk("lit_unblock_push", opsum_push, 32'hFF);
    @(posedge clk); #1;
    run_job(0, done_at, nmv, dpush, ipp);
    chk("lit_unblock_moves", nmv, 1);
    chk("lit_unblock_done", done_at, 33);
    opsum_full = '0;

    // Zero tokens skips NORMAL; a mid-run start with new config is ignored.
    start_job(32'hFFFF_FFFF, 16'd0, 2'b00);
    repeat (9) step();
    col_en_mask = '0; num_tokens = 16'd5; start_i = 1'b1;
    step();
    start_i = 1'b0;
    run_job(11, done_at, nmv, dpush, ipp);
    chk("lit_zero_tok_done", done_at, 65);
    chk("lit_zero_tok_moves", nmv, 0);
    @(negedge clk); chk("lit_no_restart", busy, 1'b0);
    @(posedge clk); #1;

    // Reset in the middle of DRAIN, then a zero-mask job.
    start_job(32'hFFFF_FFFF, 16'd0, 2'b00);
    repeat (39) step();
    @(negedge clk);
    chk("lit_in_drain", {busy, preheat_state, normal_loop_state}, 3'b100);
    @(posedge clk); #1;
    rst_n = 1'b0;
    step();
    @(negedge clk);
    chk("lit_rst_busy_done", {busy, done, pe_array_move}, 3'b000);
    chk("lit_rst_strobes", {ifmap_pop, ipsum_pop, opsum_push}, '0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    step();
    start_job(32'h0, 16'd2, 2'b10);
    run_job(1, done_at, nmv, dpush, ipp);
    chk("lit_mask0_done", done_at, 67);
    chk("lit_mask0_moves", nmv, 2);
    step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/pe_array_token_sequencer.md
PE_ARRAY_TOKEN_SEQUENCER -- requirements
Module: pe_array_token_sequencer

Interface
REQ-001 SHALL have ports: clk in 1, rising-edge clock; rst_n in 1, synchronous active-low reset.
REQ-002 SHALL have ports: start_i in 1, start pulse; layer_type_i in 2, layer type; col_en_mask_i in 32, active PE columns; num_tokens_i in 16, normal-loop token count.
REQ-003 SHALL have ports: ifmap_fifo_empty_i in 32, ipsum_fifo_empty_i in 32, opsum_fifo_full_i in 32; per-column FIFO status.
REQ-004 SHALL have ports: preheat_state_o out 1, normal_loop_state_o out 1; phase flags to the PE array controller.
REQ-005 SHALL have ports: ifmap_fifo_pop_matrix_o out 32, ipsum_fifo_pop_matrix_o out 32, opsum_fifo_push_matrix_o out 32; per-column FIFO strobes.
REQ-006 SHALL have ports: pe_array_move_o out 1, array advance; busy_o out 1; done_o out 1, one-cycle completion pulse.

Function
REQ-007 SHALL implement FSM IDLE, PREHEAT, NORMAL, DRAIN, DONE.
REQ-008 SHALL, in IDLE on start_i=1, latch layer_type_i, col_en_mask_i and num_tokens_i, clear counters, and enter PREHEAT next cycle.
REQ-009 SHALL ignore start_i in every state other than IDLE.
REQ-010 SHALL drive preheat_state_o=1 only in PREHEAT and normal_loop_state_o=1 only in NORMAL, both decoded from the registered state.
REQ-011 SHALL, in PREHEAT, keep a 5-bit step counter k; step fires when every latched-mask column j<=k has ifmap_fifo_empty_i[j]=0.
REQ-012 SHALL, on a PREHEAT step, drive ifmap_fifo_pop_matrix_o = mask & bits[k:0] in the same cycle (combinational) and increment k; otherwise pop=0 and k holds.
REQ-013 SHALL exit PREHEAT after the step with k=31: to NORMAL if num_tokens!=0, else to DRAIN.
REQ-014 SHALL, in NORMAL, assert pe_array_move_o when, for all masked columns, ifmap is non-empty, ipsum is non-empty (unless bypassed) and opsum is not full; all combinational.
REQ-015 SHALL, on NORMAL move, drive ifmap pop = mask, ipsum pop = mask (0 if bypassed) and opsum push = mask; otherwise all three are 0.
REQ-016 SHALL bypass ipsum (ignore ipsum_fifo_empty_i, no ipsum pops) when latched layer_type = LT_DW (2'b01).
REQ-017 SHALL count NORMAL moves in 16 bits and enter DRAIN on the move that makes count = num_tokens.
REQ-018 SHALL, in DRAIN, assert pe_array_move_o and opsum push = mask when no masked opsum FIFO is full, with no pops, and leave after 32 moves.
REQ-019 SHALL assert done_o for exactly the one DONE cycle, then return to IDLE.
REQ-020 SHALL hold busy_o=1 in every state except IDLE.
REQ-021 SHALL treat col_en_mask=0 as all columns ready: steps and moves fire every cycle and all strobes are 0.
REQ-022 SHALL drive all strobes and pe_array_move_o to 0 in IDLE and DONE.

Reset
REQ-023 SHALL, on rst_n=0 at a clock edge, enter IDLE, clear all counters and latched config, and drive every output to 0 from the next cycle.
REQ-024 SHALL, on reset mid-operation, abandon the job without a done_o pulse.

Configuration
REQ-025 SHALL, when SEQ_PERF_CNT_EN is defined, add stall_cnt_o out 32 that counts cycles busy with no step or move, clears on start acceptance and saturates at all-ones.
REQ-026 SHALL, when SEQ_PERF_CNT_EN is undefined, omit stall_cnt_o and its logic.

Structure
REQ-027 SHALL take its state enum, PE_ARRAY_DIM=32, LT_PW=2'b00, LT_DW=2'b01, LT_STD=2'b10 and DRAIN_CYCLES=32 from a shared package, token_engine_pkg.
REQ-028 SHALL use one sub-module, fifo_ready_reduce: a masked AND-reduction of per-column ready with a prefix-limit input, instantiated three times.

Verification
REQ-029 SHALL cover: mask=32'hFFFFFFFF, num_tokens=4, all FIFOs ready -> 32 preheat cycles with pops 0x1, 0x3, ... 0xFFFFFFFF; 4 NORMAL moves; 32 DRAIN pushes; done_o at cycle 70 after start.
REQ-030 SHALL cover: ifmap_fifo_empty_i[3]=1 for 5 cycles at k=3 -> k holds 5 cycles with pop 0; the sequence resumes unchanged.
REQ-031 SHALL cover: layer_type=LT_DW with ipsum_fifo_empty_i=all-ones -> NORMAL moves proceed and ipsum pops stay 0.
REQ-032 SHALL cover: opsum_fifo_full_i[7]=1 with mask=0x000000FF in NORMAL -> move=0 and all strobes 0 until it clears.
REQ-033 SHALL cover: num_tokens=0 -> PREHEAT goes directly to DRAIN; a start_i during the run is ignored.
REQ-034 SHALL cover: rst_n=0 mid-DRAIN -> all outputs 0 next cycle, no done_o, and a new start is accepted afterwards.
